// File: rtl/f_matvec.sv
`default_nettype none
// ============================================================================
// Module      : f_matvec
// Description : Streaming matrix-vector product f = H * x. A vector x is
//               latched once, then I rows of H are accepted one at a time.
//               Each row is multiply-accumulated serially, one column per
//               cycle, and its dot product is presented on the f stream.
//               Compile-time option F_MATVEC_SAT_EN: when defined, f clamps
//               to the signed OW-bit range and sat_flag latches any clamp;
//               when undefined, f wraps and sat_flag is tied low.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               x/x_tvalid/x_tready - x vector stream (J elements of XW)
//               h/h_tvalid/h_tready - H row stream (J elements of HW)
//               f/f_tvalid/f_tready - result stream, f_tlast on row I-1
//               sat_flag          - sticky saturation indicator
// Revision    : 1.0 - initial release
// ============================================================================
module f_matvec #(
    parameter int J  = 14,
    parameter int I  = 7,
    parameter int HW = 16,
    parameter int XW = 2,
    parameter int OW = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [J*XW-1:0]  x,
    input  logic             x_tvalid,
    output logic             x_tready,
    input  logic [J*HW-1:0]  h,
    input  logic             h_tvalid,
    output logic             h_tready,
    output logic [OW-1:0]    f,
    output logic             f_tvalid,
    input  logic             f_tready,
    output logic             f_tlast,
    output logic             sat_flag
);

    localparam int ACCW = HW + XW + $clog2(J) + 1;
    localparam int PW   = HW + XW;
    localparam int KW   = (J > 1) ? $clog2(J) : 1;
    localparam int RW   = (I > 1) ? $clog2(I) : 1;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_WAIT_H = 2'd1;
    localparam logic [1:0] c_MAC    = 2'd2;
    localparam logic [1:0] c_OUT    = 2'd3;

    localparam logic [KW-1:0] c_KLAST = KW'(J - 1);
    localparam logic [RW-1:0] c_RLAST = RW'(I - 1);

    logic [1:0]       state_q, state_d;
    logic [J*XW-1:0]  x_q, x_d;
    logic [J*HW-1:0]  h_q, h_d;
    logic [ACCW-1:0]  acc_q, acc_d;
    logic [KW-1:0]    k_q, k_d;
    logic [RW-1:0]    row_q, row_d;

    // Current column product. Both operands are sign-extended to the full
    // product width first so the multiply is exact at that width.
    logic [HW-1:0]    w_h_el;
    logic [XW-1:0]    w_x_el;
    logic [PW-1:0]    w_h_ext, w_x_ext;
    logic [PW-1:0]    w_prod;
    logic [ACCW-1:0]  w_prod_ext;

    assign w_h_el     = h_q[k_q*HW +: HW];
    assign w_x_el     = x_q[k_q*XW +: XW];
    assign w_h_ext    = {{XW{w_h_el[HW-1]}}, w_h_el};
    assign w_x_ext    = {{HW{w_x_el[XW-1]}}, w_x_el};
    assign w_prod     = $signed(w_h_ext) * $signed(w_x_ext);
    assign w_prod_ext = {{(ACCW-PW){w_prod[PW-1]}}, w_prod};

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
            x_q     <= '0;
            h_q     <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            h_q     <= h_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            row_q   <= row_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:   if (x_tvalid)         state_d = c_WAIT_H;
            c_WAIT_H: if (h_tvalid)         state_d = c_MAC;
            c_MAC:    if (k_q == c_KLAST)   state_d = c_OUT;
            c_OUT:    if (f_tready)         state_d = (row_q == c_RLAST) ? c_IDLE : c_WAIT_H;
            default:                        state_d = c_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        x_d   = x_q;
        h_d   = h_q;
        acc_d = acc_q;
        k_d   = k_q;
        row_d = row_q;
        case (state_q)
            c_IDLE: begin
                if (x_tvalid) begin
                    x_d   = x;
                    row_d = '0;
                end
            end
            c_WAIT_H: begin
                if (h_tvalid) begin
                    h_d   = h;
                    acc_d = '0;
                    k_d   = '0;
                end
            end
            c_MAC: begin
                acc_d = acc_q + w_prod_ext;
                if (k_q != c_KLAST) k_d = k_q + 1'b1;
            end
            c_OUT: begin
                if (f_tready && (row_q != c_RLAST)) row_d = row_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Output logic
    always_comb begin
        x_tready = (state_q == c_IDLE);
        h_tready = (state_q == c_WAIT_H);
        f_tvalid = (state_q == c_OUT);
        f_tlast  = (state_q == c_OUT) && (row_q == c_RLAST);
    end

`ifdef F_MATVEC_SAT_EN
    logic w_ovf;
    logic sat_q, sat_d;
`endif

    // Result formatting: narrow the accumulator to OW bits (wrap or clamp),
    // or sign-extend it when OW is wider than the accumulator.
    generate
        if (OW < ACCW) begin : g_narrow
`ifdef F_MATVEC_SAT_EN
            // Out of range whenever the bits above the OW-bit sign bit do
            // not all match it.
            logic [ACCW-OW:0] w_upper;
            assign w_upper = acc_q[ACCW-1:OW-1];
            assign w_ovf   = !((&w_upper) || (~|w_upper));
            assign f       = !w_ovf        ? acc_q[OW-1:0] :
                             acc_q[ACCW-1] ? {1'b1, {(OW-1){1'b0}}} :
                                             {1'b0, {(OW-1){1'b1}}};
`else
            assign f = acc_q[OW-1:0];
`endif
        end else if (OW == ACCW) begin : g_equal
`ifdef F_MATVEC_SAT_EN
            assign w_ovf = 1'b0;
`endif
            assign f = acc_q;
        end else begin : g_wide
`ifdef F_MATVEC_SAT_EN
            assign w_ovf = 1'b0;
`endif
            assign f = {{(OW-ACCW){acc_q[ACCW-1]}}, acc_q};
        end
    endgenerate

`ifdef F_MATVEC_SAT_EN
    // Set while a clamped result is being presented; cleared only by reset.
    assign sat_d = sat_q | ((state_q == c_OUT) && w_ovf);

    always_ff @(posedge clk) begin
        if (rst) sat_q <= 1'b0;
        else     sat_q <= sat_d;
    end

    assign sat_flag = sat_q;
`else
    assign sat_flag = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/f_matvec.md
F_MATVEC -- requirements
Module: f_matvec

Interface
REQ-001 SHALL have parameter J, default 14, meaning columns per row (vector length), J >= 1.
REQ-002 SHALL have parameter I, default 7, meaning rows per matrix (outputs per x vector), I >= 1.
REQ-003 SHALL have parameter HW, default 16, meaning signed H element width.
REQ-004 SHALL have parameter XW, default 2, meaning signed x element width.
REQ-005 SHALL have parameter OW, default 24, meaning signed result width; internal accumulator width is HW+XW+clog2(J)+1.
REQ-006 SHALL have port clk, input, 1 bit, sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit, reset that is synchronous and active-high.
REQ-008 SHALL have port x, input, J*XW bits, x vector, element k at bits [k*XW +: XW].
REQ-009 SHALL have ports x_tvalid (input, 1 bit) and x_tready (output, 1 bit), x handshake.
REQ-010 SHALL have port h, input, J*HW bits, one H row, element k at bits [k*HW +: HW].
REQ-011 SHALL have ports h_tvalid (input, 1 bit) and h_tready (output, 1 bit), row handshake.
REQ-012 SHALL have port f, output, OW bits, dot product of the current row with x.
REQ-013 SHALL have ports f_tvalid (output, 1 bit) and f_tready (input, 1 bit), result handshake.
REQ-014 SHALL have port f_tlast, output, 1 bit, high with the result of row I-1.
REQ-015 SHALL have port sat_flag, output, 1 bit, sticky overflow indicator.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT_H, MAC, OUT.
- IDLE: x_tready=1; x_tvalid&x_tready latches x, row counter=0, goes to WAIT_H.
- WAIT_H: h_tready=1; h_tvalid&h_tready latches h, clears the accumulator and column counter, goes to MAC.
- MAC: adds one product h[k]*x[k] per cycle, k=0..J-1; goes to OUT after the k=J-1 add.
- OUT: f_tvalid=1; f and f_tlast stay stable until f_tready.
REQ-017 SHALL use signed two's-complement arithmetic throughout; each product SHALL be sign-extended to the accumulator width.
REQ-018 SHALL assert f_tvalid exactly J+1 cycles after the h handshake cycle when f_tready is held high.
REQ-019 SHALL, on the OUT handshake, go to WAIT_H if the row counter < I-1 (incrementing it), otherwise go to IDLE.
REQ-020 SHALL hold x_tready and h_tready low in every state other than their own; x_tvalid outside IDLE and h_tvalid outside WAIT_H SHALL be ignored.
REQ-021 SHALL give J=1 a single MAC cycle and I=1 f_tlast=1 on every result.
REQ-022 SHALL, without the saturation feature, drive f with the low OW bits of the accumulator (wrap-around).

Reset
REQ-023 SHALL, in the cycle after rst is sampled high, be in state IDLE with x_tready=1, h_tready=0, f_tvalid=0, f=0, f_tlast=0, sat_flag=0, and all counters and the accumulator at 0.
REQ-024 SHALL, on reset in any state (including mid-MAC or in OUT), discard partial results and the latched x; reset SHALL take priority over all handshakes in the same cycle.

Configuration
REQ-025 SHALL support the macro F_MATVEC_SAT_EN.
- Defined: f saturates to [-2^(OW-1), 2^(OW-1)-1]; sat_flag sets when a saturated result is presented and clears only on reset.
- Undefined: wrap per REQ-022; sat_flag is tied to 0.

Verification (J=4, I=2, HW=16, XW=3, OW=20 unless stated)
REQ-026 Basic: x=[1,-1,2,0]; rows [10,20,30,40] then [1,1,1,1] -> f=50 with f_tlast=0, then f=2 with f_tlast=1, then x_tready=1.
REQ-027 Latency: row accepted at cycle T with f_tready=1 -> f_tvalid first high at T+5, low the cycle after the handshake.
REQ-028 Backpressure: f_tready low for 5 cycles in OUT -> f, f_tvalid, f_tlast stable, h_tready=0 throughout; completes on the first f_tready=1.
REQ-029 Overflow (OW=16): h all 32767, x all 3 -> without the macro f=-12, sat_flag=0; with the macro f=32767, sat_flag=1 and stays 1.
REQ-030 Reset mid-MAC: rst high on the 2nd MAC cycle -> next cycle IDLE, f_tvalid=0, x_tready=1; new x and rows produce correct results unaffected by prior data.
REQ-031 Ignored input: x_tvalid pulsed with a different x during WAIT_H/MAC -> results use the originally latched x.
